// File: rtl/permute_controller.sv
// Moore control FSM that sequences the permutation datapath: one element moved per
// READ..CHECK iteration, with bounded +5 correction (FIX) cycles and an iteration budget.
module permute_controller #(
  parameter int MAXITER = 24,
  parameter int MAXFIX  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  input  logic done,
  input  logic sign,
  output logic initLine,
  output logic IJen,
  output logic IJregen,
  output logic read,
  output logic firstread,
  output logic writeVal,
  output logic writeMemReg,
  output logic ldTillPositive,
  output logic waitCalNexti,
  output logic update,
  output logic write,
  output logic ok,
  output logic busy,
  output logic finished,
  output logic err
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_READ, S_CALC, S_FIX, S_UPD, S_WRITE, S_CHECK, S_DONE
  } state_t;

  localparam logic [4:0] ITER_MAX = 5'(MAXITER);
  localparam logic [2:0] FIX_MAX  = 3'(MAXFIX);
  localparam logic [2:0] FIX_LAST = 3'(MAXFIX - 1);

  state_t     state;
  state_t     next;
  logic       set_err;
  logic [4:0] iter_cnt;
  logic [2:0] fix_cnt;

  // fix_cnt counts FIX cycles already completed, so FIX_LAST marks the final allowed one
  always_comb begin
    next    = state;
    set_err = 1'b0;
    case (state)
      S_IDLE:  if (start) next = S_INIT;
      S_INIT:  next = S_READ;
      S_READ:  next = S_CALC;
      S_CALC:  next = sign ? S_FIX : S_UPD;
      S_FIX: begin
        if (!sign) begin
          next = S_UPD;
        end else if (fix_cnt == FIX_LAST) begin
          next    = S_DONE;
          set_err = 1'b1;
        end
      end
      S_UPD:   next = S_WRITE;
      S_WRITE: next = S_CHECK;
      S_CHECK: begin
        if (done) begin
          next = S_DONE;
        end else if (iter_cnt == ITER_MAX) begin
          next    = S_DONE;
          set_err = 1'b1;
        end else begin
          next = S_READ;
        end
      end
      S_DONE:  if (ack) next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      iter_cnt       <= '0;
      fix_cnt        <= '0;
      err            <= 1'b0;
      initLine       <= 1'b0;
      IJen           <= 1'b0;
      IJregen        <= 1'b0;
      read           <= 1'b0;
      firstread      <= 1'b0;
      writeVal       <= 1'b0;
      writeMemReg    <= 1'b0;
      ldTillPositive <= 1'b0;
      waitCalNexti   <= 1'b0;
      update         <= 1'b0;
      write          <= 1'b0;
      ok             <= 1'b0;
      busy           <= 1'b0;
      finished       <= 1'b0;
    end else begin
      state <= next;

      case (state)
        S_INIT:  iter_cnt <= '0;
        S_WRITE: if (iter_cnt != ITER_MAX) iter_cnt <= iter_cnt + 5'd1;
        S_CALC:  fix_cnt <= '0;
        S_FIX:   if (fix_cnt != FIX_MAX) fix_cnt <= fix_cnt + 3'd1;
        default: ;
      endcase

      if (next == S_INIT)
        err <= 1'b0;
      else if (set_err)
        err <= 1'b1;

      initLine       <= (next == S_INIT);
      IJen           <= (next == S_INIT);
      IJregen        <= (next == S_INIT) || (next == S_UPD);
      read           <= (next == S_READ);
      firstread      <= (next == S_READ) && (state == S_INIT);
      writeVal       <= (next == S_READ);
      writeMemReg    <= (next == S_READ);
      ldTillPositive <= (next == S_CALC) || (next == S_FIX);
      waitCalNexti   <= (next == S_FIX);
      update         <= (next == S_UPD);
      write          <= (next == S_WRITE);
      ok             <= (next == S_DONE);
      finished       <= (next == S_DONE);
      busy           <= (next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_permute_controller.sv
// Self-checking bench: a per-cycle expected trace is built from run descriptions
// (iterations, FIX lengths, done point) and replayed against the controller.
module tb_permute_controller;

  logic clk = 1'b0;
  logic rst, start, ack, done, sign;
  logic initLine, IJen, IJregen, read, firstread, writeVal, writeMemReg;
  logic ldTillPositive, waitCalNexti, update, write, ok, busy, finished, err;

  permute_controller dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack), .done(done), .sign(sign),
    .initLine(initLine), .IJen(IJen), .IJregen(IJregen), .read(read),
    .firstread(firstread), .writeVal(writeVal), .writeMemReg(writeMemReg),
    .ldTillPositive(ldTillPositive), .waitCalNexti(waitCalNexti),
    .update(update), .write(write), .ok(ok), .busy(busy),
    .finished(finished), .err(err)
  );

  always #5 clk = ~clk;

  // Bit order: initLine IJen IJregen read firstread writeVal writeMemReg
  //            ldTillPositive waitCalNexti update write ok busy finished
  localparam logic [13:0] W_IDLE  = 14'b00000000000000;
  localparam logic [13:0] W_INIT  = 14'b11100000000010;
  localparam logic [13:0] W_READ  = 14'b00010110000010;
  localparam logic [13:0] W_READF = 14'b00011110000010;
  localparam logic [13:0] W_CALC  = 14'b00000001000010;
  localparam logic [13:0] W_FIX   = 14'b00000001100010;
  localparam logic [13:0] W_UPD   = 14'b00100000010010;
  localparam logic [13:0] W_WRITE = 14'b00000000001010;
  localparam logic [13:0] W_CHECK = 14'b00000000000010;
  localparam logic [13:0] W_DONE  = 14'b00000000000111;
  localparam int MAX_ITER = 24;
  localparam int MAX_FIX  = 7;

  typedef struct {
    logic [13:0] word;
    bit          chk_err;
    bit          err_exp;
    bit          sg;
    bit          dn;
    bit          st;
    bit          ak;
  } step_t;

  step_t q[$];
  int errors = 0;
  int checks = 0;
  int writes_seen = 0;

  wire [13:0] obs_word = {initLine, IJen, IJregen, read, firstread, writeVal, writeMemReg,
                          ldTillPositive, waitCalNexti, update, write, ok, busy, finished};

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [13:0] word, input bit sg, input bit dn, input bit st,
                      input bit ak, input bit chk_err, input bit err_exp);
    step_t s;
    s.word = word; s.sg = sg; s.dn = dn; s.st = st; s.ak = ak;
    s.chk_err = chk_err; s.err_exp = err_exp;
    q.push_back(s);
  endtask

  // Expected trace of one run. fix_len = number of FIX cycles wanted in iteration fix_at;
  // more than MAX_FIX means sign never clears. done_at = 0 means done never rises.
  task automatic build_run(input int done_at, input int fix_at, input int fix_len,
                           input bit rand_fix, input bit hold);
    int  f;
    bit  abort_run;
    bit  err_exp;
    bit  s;
    push(W_IDLE, rb(), rb(), 1'b1, rb(), 1'b0, 1'b0);
    push(W_INIT, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
    err_exp = 1'b0;
    for (int it = 1; it <= MAX_ITER; it++) begin
      f = (it == fix_at) ? fix_len : (rand_fix ? int'($urandom_range(0, 2)) : 0);
      push((it == 1) ? W_READF : W_READ, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
      push(W_CALC, (f > 0), rb(), rb(), rb(), 1'b0, 1'b0);
      abort_run = 1'b0;
      if (f > 0) begin
        for (int k = 1; k <= MAX_FIX; k++) begin
          s = (k < f);
          push(W_FIX, s, rb(), rb(), rb(), 1'b0, 1'b0);
          if (!s) break;
          if (k == MAX_FIX) abort_run = 1'b1;
        end
      end
      if (abort_run) begin
        err_exp = 1'b1;
        break;
      end
      push(W_UPD, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
      push(W_WRITE, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
      push(W_CHECK, rb(), (it == done_at), rb(), rb(), 1'b0, 1'b0);
      if (it == done_at) break;
      if (it == MAX_ITER) err_exp = 1'b1;
    end
    if (hold) begin
      for (int h = 0; h < 4; h++) push(W_DONE, rb(), rb(), 1'b1, 1'b0, 1'b1, err_exp);
      push(W_DONE, rb(), rb(), 1'b1, 1'b1, 1'b1, err_exp);
      for (int h = 0; h < 3; h++) push(W_IDLE, rb(), rb(), 1'b0, rb(), 1'b0, 1'b0);
    end else begin
      push(W_DONE, rb(), rb(), rb(), 1'b1, 1'b1, err_exp);
    end
  endtask

  task automatic apply_stimulus(input string tag, input int max_steps);
    step_t s;
    int n;
    n = 0;
    while (q.size() > 0 && n < max_steps) begin
      s = q.pop_front();
      @(negedge clk);
      check_output(tag, {2'b0, obs_word}, {2'b0, s.word});
      if (s.chk_err) check_output({tag, "_err"}, {15'b0, err}, {15'b0, s.err_exp});
      if (write) writes_seen++;
      start = s.st; ack = s.ak; sign = s.sg; done = s.dn;
      n++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ack = 1'b0; done = 1'b0; sign = 1'b0;
    #1;
    check_output("reset_outputs", {2'b0, obs_word}, 16'h0000);
    check_output("reset_err", {15'b0, err}, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    $display("[TB] basic three-iteration run");
    build_run(3, 0, 0, 1'b0, 1'b0);
    apply_stimulus("basic", 1000);

    $display("[TB] iteration with three FIX cycles");
    build_run(2, 1, 3, 1'b0, 1'b0);
    apply_stimulus("fix3", 1000);

    $display("[TB] FIX budget overrun");
    writes_seen = 0;
    build_run(0, 1, 50, 1'b0, 1'b0);
    apply_stimulus("fix_overrun", 1000);
    check_output("fix_overrun_writes", 16'(writes_seen), 16'd0);

    $display("[TB] iteration budget overrun");
    writes_seen = 0;
    build_run(0, 0, 0, 1'b0, 1'b0);
    apply_stimulus("iter_overrun", 1000);
    check_output("iter_overrun_writes", 16'(writes_seen), 16'(MAX_ITER));

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      build_run(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                (r == 2) ? 9 : int'($urandom_range(0, 7)), 1'b1, 1'b0);
      apply_stimulus("random_run", 1000);
    end

    $display("[TB] reset during FIX");
    build_run(0, 1, 20, 1'b0, 1'b0);
    apply_stimulus("pre_reset", 7);
    q.delete();
    @(negedge clk);
    check_output("in_fix_before_reset", {2'b0, obs_word}, {2'b0, W_FIX});
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_outputs", {2'b0, obs_word}, 16'h0000);
    check_output("async_reset_err", {15'b0, err}, 16'h0000);
    start = 1'b0; sign = 1'b0; done = 1'b0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("after_reset_idle", {2'b0, obs_word}, 16'h0000);
    build_run(2, 0, 0, 1'b0, 1'b0);
    apply_stimulus("restart", 1000);

    $display("[TB] DONE hold with start, then ack");
    build_run(1, 1, 2, 1'b0, 1'b1);
    apply_stimulus("done_hold", 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
